// File: rtl/ac97_record_buffer_pkg.sv
// Shared types and helpers for the AC97 record buffer.
// Holds the FSM state encoding, the default sample width and the stereo-to-mono mix.
package ac97_record_buffer_pkg;

    localparam int SAMPLE_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    // The caller sign-extends both channels to 32 bits, so the sum cannot overflow.
    // The caller then truncates the result back to its own sample width.
    function automatic logic signed [31:0] mono_mix(input logic signed [31:0] left,
                                                    input logic signed [31:0] right);
        logic signed [31:0] sum;
        sum = left + right;
        return sum >>> 1;
    endfunction

endpackage

// File: rtl/ac97_record_buffer_if.sv
// Codec-side and control/status signals of the AC97 record buffer.
// The slave modport is the buffer; the master modport is the codec and control side.
interface ac97_record_buffer_if
    import ac97_record_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) ();
    logic                    record_button;
    logic                    play_button;
    logic                    record_valid;
    logic [SAMPLE_WIDTH-1:0] record_left;
    logic [SAMPLE_WIDTH-1:0] record_right;
    logic                    new_frame;
    logic [SAMPLE_WIDTH-1:0] sample_out;
    logic                    recording;
    logic                    playing;
    logic                    full;
    logic [ADDR_WIDTH:0]     length;

    modport slave (
        input  record_button, play_button, record_valid, record_left, record_right, new_frame,
        output sample_out, recording, playing, full, length
    );

    modport master (
        output record_button, play_button, record_valid, record_left, record_right, new_frame,
        input  sample_out, recording, playing, full, length
    );
endinterface

// File: rtl/ac97_record_buffer_record_ram.sv
// Sample store for the record buffer: 2^ADDR_WIDTH x DATA_WIDTH.
// One synchronous write port and one synchronous read port, no reset, so it can map to block RAM.
module ac97_record_buffer_record_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/ac97_record_buffer.sv
// AC97 record buffer: down-mixes codec record samples to mono, stores them, replays on command.
// Define RECORD_LOOP_EN to make playback loop forever instead of stopping after the last sample.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a button; sample_out silent after the last frame
// ST_RECORD | writing one mono sample per record_valid
// ST_PLAY   | emitting one stored sample per new_frame
module ac97_record_buffer
    import ac97_record_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) (
    input logic                 clk,
    input logic                 reset,
    ac97_record_buffer_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'((1 << ADDR_WIDTH) - 1);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]     length_q;
    logic                    full_q;
    logic [SAMPLE_WIDTH-1:0] sample_q, mix_sample, rd_data;
    logic                    load_pend, zero_pend, last_pend;
    logic                    wr_en, rd_en, rd_at_end;

    assign mix_sample = SAMPLE_WIDTH'(mono_mix(32'(signed'(bus.record_left)),
                                               32'(signed'(bus.record_right))));
    assign wr_en      = (state == ST_RECORD) && bus.record_valid;
    assign rd_en      = (state == ST_PLAY) && bus.new_frame;
    assign rd_at_end  = ({1'b0, rd_ptr} == (length_q - 1'b1));

    ac97_record_buffer_record_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (SAMPLE_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (mix_sample),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.record_button) begin
                    state_nxt = ST_RECORD;
                end else if (bus.play_button && (length_q != '0)) begin
                    state_nxt = ST_PLAY;
                end
            end
            ST_RECORD: begin
                if (bus.record_button || (wr_en && (wr_ptr == LAST_ADDR))) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (bus.play_button || last_pend) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.recording = (state == ST_RECORD);
        bus.playing   = (state == ST_PLAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            length_q  <= '0;
            full_q    <= 1'b0;
            sample_q  <= '0;
            load_pend <= 1'b0;
            zero_pend <= 1'b0;
            last_pend <= 1'b0;
        end else begin
            // A read issued this cycle lands in sample_out one cycle later.
            load_pend <= rd_en && !bus.play_button;
            zero_pend <= (state == ST_IDLE) && bus.new_frame;
`ifdef RECORD_LOOP_EN
            last_pend <= 1'b0;
`else
            last_pend <= rd_en && !bus.play_button && rd_at_end;
`endif
            case (state)
                ST_IDLE: begin
                    if (bus.record_button) begin
                        wr_ptr   <= '0;
                        full_q   <= 1'b0;
                        length_q <= '0;
                    end else if (bus.play_button && (length_q != '0)) begin
                        rd_ptr <= '0;
                    end
                end
                ST_RECORD: begin
                    if (wr_en) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        length_q <= length_q + 1'b1;
                        if (wr_ptr == LAST_ADDR) begin
                            full_q <= 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (rd_en) begin
                        rd_ptr <= rd_at_end ? '0 : rd_ptr + 1'b1;
                    end
                end
                default: ;
            endcase

            if ((state == ST_PLAY) && bus.play_button) begin
                sample_q <= '0;
            end else if (load_pend) begin
                sample_q <= rd_data;
            end else if (zero_pend || ((state == ST_IDLE) && bus.record_button)) begin
                sample_q <= '0;
            end
        end
    end

    assign bus.sample_out = sample_q;
    assign bus.full       = full_q;
    assign bus.length     = length_q;
endmodule

// File: tb/tb_ac97_record_buffer.sv
// Directed test of ac97_record_buffer at ADDR_WIDTH=3 with hand-computed expectations.
module tb_ac97_record_buffer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    ac97_record_buffer_if #(.ADDR_WIDTH(3), .SAMPLE_WIDTH(16)) bus ();

    ac97_record_buffer #(.ADDR_WIDTH(3), .SAMPLE_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic pulse_rec();
        bus.record_button = 1'b1;
        tick();
        bus.record_button = 1'b0;
    endtask

    task automatic pulse_play();
        bus.play_button = 1'b1;
        tick();
        bus.play_button = 1'b0;
    endtask

    task automatic rec_sample(input logic [15:0] l, input logic [15:0] r);
        bus.record_valid = 1'b1;
        bus.record_left  = l;
        bus.record_right = r;
        tick();
        bus.record_valid = 1'b0;
        tick();
    endtask

    task automatic frame();
        bus.new_frame = 1'b1;
        tick();
        bus.new_frame = 1'b0;
        tick();
    endtask

    task automatic stop_if_playing();
        if (bus.playing) pulse_play();
    endtask

    initial begin
        bus.record_button = 1'b0;
        bus.play_button   = 1'b0;
        bus.record_valid  = 1'b0;
        bus.record_left   = '0;
        bus.record_right  = '0;
        bus.new_frame     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst_sample", 32'(bus.sample_out), 32'h0);
        check("rst_recording", 32'(bus.recording), 32'h0);
        check("rst_playing", 32'(bus.playing), 32'h0);
        check("rst_full", 32'(bus.full), 32'h0);
        check("rst_length", 32'(bus.length), 32'h0);

        pulse_play();
        check("empty_playing", 32'(bus.playing), 32'h0);
        frame();
        check("empty_sample", 32'(bus.sample_out), 32'h0);

        pulse_rec();
        check("rt_recording", 32'(bus.recording), 32'h1);
        rec_sample(16'h0010, 16'h0010);
        rec_sample(16'h0020, 16'h0020);
        rec_sample(16'h0030, 16'h0030);
        rec_sample(16'h0040, 16'h0040);
        check("rt_len_mid", 32'(bus.length), 32'h4);
        pulse_rec();
        check("rt_rec_off", 32'(bus.recording), 32'h0);
        check("rt_length", 32'(bus.length), 32'h4);
        check("rt_full", 32'(bus.full), 32'h0);

        pulse_play();
        check("rt_playing", 32'(bus.playing), 32'h1);
        frame(); check("rt_s0", 32'(bus.sample_out), 32'h0010);
        frame(); check("rt_s1", 32'(bus.sample_out), 32'h0020);
        frame(); check("rt_s2", 32'(bus.sample_out), 32'h0030);
        frame(); check("rt_s3", 32'(bus.sample_out), 32'h0040);
        frame();
`ifdef RECORD_LOOP_EN
        check("rt_s4_loop", 32'(bus.sample_out), 32'h0010);
        check("rt_play_loop", 32'(bus.playing), 32'h1);
`else
        check("rt_s4_end", 32'(bus.sample_out), 32'h0000);
        check("rt_play_end", 32'(bus.playing), 32'h0);
`endif
        stop_if_playing();
        check("rt_stop_sample", 32'(bus.sample_out), 32'h0);

        pulse_rec();
        rec_sample(16'h7FFF, 16'h7FFF);
        rec_sample(16'h8000, 16'h8000);
        rec_sample(16'h0001, 16'hFFFF);
        rec_sample(16'h0003, 16'h0000);
        pulse_rec();
        check("mix_length", 32'(bus.length), 32'h4);
        pulse_play();
        frame(); check("mix_max", 32'(bus.sample_out), 32'h7FFF);
        frame(); check("mix_min", 32'(bus.sample_out), 32'h8000);
        frame(); check("mix_cancel", 32'(bus.sample_out), 32'h0000);
        frame(); check("mix_round", 32'(bus.sample_out), 32'h0001);
        stop_if_playing();

        pulse_rec();
        for (int k = 1; k <= 8; k++) rec_sample(16'(k * 16'h0100), 16'(k * 16'h0100));
        check("full_flag", 32'(bus.full), 32'h1);
        check("full_length", 32'(bus.length), 32'h8);
        check("full_recording", 32'(bus.recording), 32'h0);
        rec_sample(16'h0900, 16'h0900);
        check("full_no_ninth", 32'(bus.length), 32'h8);
        pulse_play();
        for (int k = 1; k <= 8; k++) begin
            frame();
            check($sformatf("full_s%0d", k), 32'(bus.sample_out), 32'(k * 32'h0100));
        end
        stop_if_playing();

        bus.record_button = 1'b1;
        bus.play_button   = 1'b1;
        tick();
        bus.record_button = 1'b0;
        bus.play_button   = 1'b0;
        check("both_recording", 32'(bus.recording), 32'h1);
        check("both_playing", 32'(bus.playing), 32'h0);
        check("both_length", 32'(bus.length), 32'h0);
        check("both_full", 32'(bus.full), 32'h0);

        rec_sample(16'h0100, 16'h0100);
        rec_sample(16'h0200, 16'h0200);
        rec_sample(16'h0300, 16'h0300);
        check("part_length", 32'(bus.length), 32'h3);
        bus.record_button = 1'b1;
        bus.record_valid  = 1'b1;
        bus.record_left   = 16'h0400;
        bus.record_right  = 16'h0400;
        tick();
        bus.record_button = 1'b0;
        bus.record_valid  = 1'b0;
        tick();
        check("coinc_length", 32'(bus.length), 32'h4);
        check("coinc_recording", 32'(bus.recording), 32'h0);

        pulse_rec();
        rec_sample(16'h0111, 16'h0111);
        rec_sample(16'h0222, 16'h0222);
        rec_sample(16'h0333, 16'h0333);
        reset = 1'b1;
        #1;
        check("mrst_length", 32'(bus.length), 32'h0);
        check("mrst_recording", 32'(bus.recording), 32'h0);
        check("mrst_sample", 32'(bus.sample_out), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        pulse_play();
        check("mrst_play_ignored", 32'(bus.playing), 32'h0);
        frame();
        check("mrst_sample_after", 32'(bus.sample_out), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
